// File: rtl/ro_capture_pkg.sv
// Shared types and helpers for the readout capture stage: packed capture word,
// one-hot decode result, FIFO occupancy states and the one-hot index function.
package ro_capture_pkg;

  localparam int RO_N_CH = 19;
  localparam int RO_CH_W = 5;

  typedef struct packed {
    logic [RO_CH_W-1:0] ch_idx;
    logic               pol;
    logic               eve;
  } ro_word_t;

  typedef struct packed {
    logic               valid;
    logic [RO_CH_W-1:0] idx;
  } onehot_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_t;

  // valid is set only when exactly one bit of v is set; idx is that bit's position
  function automatic onehot_t onehot_idx(input logic [RO_N_CH-1:0] v);
    onehot_t     res;
    int unsigned n_set;
    res   = '0;
    n_set = 0;
    for (int i = 0; i < RO_N_CH; i++) begin
      if (v[i]) begin
        n_set   = n_set + 1;
        res.idx = RO_CH_W'(i);
      end
    end
    res.valid = (n_set == 1);
    return res;
  endfunction

endpackage

// File: rtl/ro_capture_fifo.sv
// Single-clock capture FIFO with a registered head word that reads as zero when empty.
// The head register bypasses the incoming word when it lands in the head slot.
module ro_capture_fifo
  import ro_capture_pkg::*;
#(
  parameter int W     = 7,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [W-1:0]  r_head;

  logic [AW-1:0] w_rd_ptr_next;
  logic [AW:0]   w_count_next;
  logic          w_push_ok;
  logic          w_pop_ok;
  fifo_state_t   w_state;

  always_comb begin
    w_state = FIFO_PARTIAL;
    if (r_count == '0) begin
      w_state = FIFO_EMPTY;
    end else if (r_count == (AW+1)'(DEPTH)) begin
      w_state = FIFO_FULL;
    end
  end

  assign o_empty = (w_state == FIFO_EMPTY);
  assign o_full  = (w_state == FIFO_FULL);

  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge
  assign w_pop_ok      = i_pop & ~o_empty;
  assign w_push_ok     = i_push & (~o_full | w_pop_ok);
  assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop_ok);
  assign w_count_next  = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_ok);
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      if (w_count_next == '0) begin
        r_head <= '0;
      end else if (w_push_ok && (w_rd_ptr_next == r_wr_ptr)) begin
        r_head <= i_din;
      end else begin
        r_head <= r_mem[w_rd_ptr_next];
      end
    end
  end

  assign o_dout = r_head;

endmodule

// File: rtl/ro_capture.sv
// Readout capture: attributes bus samples to the channel whose gray bit toggled and queues them.
// Optional macro RO_CAPTURE_SPARSE_EN discards all-zero slots instead of queueing them.
module ro_capture
  import ro_capture_pkg::*;
#(
  parameter int N_CH       = RO_N_CH,
  parameter int CH_W       = RO_CH_W,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 8
) (
  input  logic              clk_master,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   gray_count,
  input  logic              bus_eve,
  input  logic              bus_pol_eve,
  output logic [CH_W+1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DROP_W-1:0] drop_count,
  output logic              slot_err
);

  logic [N_CH-1:0]   r_gray_q;
  logic              r_primed;
  logic              r_slot_err;
  logic [DROP_W-1:0] r_drop_cnt;

  logic [N_CH-1:0] w_delta;
  onehot_t         w_oh;
  logic            w_multi;
  logic            w_bus_nz;
  logic            w_push_req;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_drop;
  ro_word_t        w_word;
  ro_word_t        w_head;

  assign w_delta = gray_count ^ r_gray_q;
  assign w_oh    = onehot_idx(RO_N_CH'(w_delta));
  assign w_multi = (w_delta != '0) && !w_oh.valid;

`ifdef RO_CAPTURE_SPARSE_EN
  assign w_bus_nz = bus_eve | bus_pol_eve;
`else
  assign w_bus_nz = 1'b1;
`endif

  assign w_push_req = r_primed & enable & w_oh.valid & w_bus_nz;
  assign w_word     = {w_oh.idx + RO_CH_W'(1), bus_pol_eve, bus_eve};
  assign w_pop      = out_ready & ~w_empty;
  // A word is lost only when full and the consumer does not free a slot this edge
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk_master) begin
    if (reset) begin
      r_gray_q   <= '0;
      r_primed   <= 1'b0;
      r_slot_err <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_gray_q <= gray_count;
      r_primed <= 1'b1;
      if (r_primed && w_multi) begin
        r_slot_err <= 1'b1;
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

  ro_capture_fifo #(
    .W     ($bits(ro_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_master),
    .i_reset (reset),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_din   (w_word),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_data   = (CH_W+2)'(w_head);
  assign out_valid  = ~w_empty;
  assign drop_count = r_drop_cnt;
  assign slot_err   = r_slot_err;

endmodule

// File: tb/tb_ro_capture.sv
// Directed bench for ro_capture: gray-driven slot decode, FIFO backpressure, errors, enable, reset.
module tb_ro_capture;

  logic        clk_master = 1'b0;
  logic        reset;
  logic        enable;
  logic [18:0] gray_count;
  logic        bus_eve;
  logic        bus_pol_eve;
  logic [6:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_count;
  logic        slot_err;

  int checks   = 0;
  int failures = 0;

  ro_capture #(
    .N_CH       (19),
    .CH_W       (5),
    .FIFO_DEPTH (8),
    .DROP_W     (8)
  ) dut (
    .clk_master  (clk_master),
    .reset       (reset),
    .enable      (enable),
    .gray_count  (gray_count),
    .bus_eve     (bus_eve),
    .bus_pol_eve (bus_pol_eve),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .drop_count  (drop_count),
    .slot_err    (slot_err)
  );

  always #5 clk_master = ~clk_master;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s ok obs=%0h", tag, obs);
    end else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then inspected 1 time unit after it
  task automatic cyc();
    @(posedge clk_master);
    #1;
  endtask

  task automatic tog(input int k, input logic e, input logic p);
    gray_count  = gray_count ^ (19'(1) << k);
    bus_eve     = e;
    bus_pol_eve = p;
    cyc();
  endtask

  function automatic int tz(input int n);
    for (int i = 0; i < 19; i++) begin
      if (n[i]) return i;
    end
    return 19;
  endfunction

  function automatic logic [6:0] word(input int ch, input logic p, input logic e);
    return {5'(ch), p, e};
  endfunction

  function automatic logic [18:0] gray(input int n);
    return 19'(n ^ (n >> 1));
  endfunction

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    gray_count  = '0;
    bus_eve     = 1'b0;
    bus_pol_eve = 1'b0;
    out_ready   = 1'b1;
    cyc();
    cyc();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_drop",  32'(drop_count), 32'd0);
    chk("rst_err",   32'(slot_err),  32'd0);

    // Priming edge: no word yet
    reset = 1'b0;
    cyc();
    chk("prime_valid", 32'(out_valid), 32'd0);

    // Binary->gray counter at one slot per cycle, bus eve=1 pol=0
    for (int n = 1; n <= 8; n++) begin
      gray_count  = gray(n);
      bus_eve     = 1'b1;
      bus_pol_eve = 1'b0;
      cyc();
      chk($sformatf("seq_valid_%0d", n), 32'(out_valid), 32'd1);
      chk($sformatf("seq_data_%0d", n), 32'(out_data), 32'(word(tz(n) + 1, 1'b0, 1'b1)));
    end

    // Zero-bus slots
    for (int n = 9; n <= 11; n++) begin
      gray_count  = gray(n);
      bus_eve     = 1'b0;
      bus_pol_eve = 1'b0;
      cyc();
`ifdef RO_CAPTURE_SPARSE_EN
      chk($sformatf("zero_valid_%0d", n), 32'(out_valid), 32'd0);
`else
      chk($sformatf("zero_data_%0d", n), 32'(out_data), 32'(word(tz(n) + 1, 1'b0, 1'b0)));
`endif
    end

    // Channel 3 slot with eve=1 pol=1
    gray_count  = gray(12);
    bus_eve     = 1'b1;
    bus_pol_eve = 1'b1;
    cyc();
    chk("ch3_data", 32'(out_data), 32'h0F);

    // Stalled counter drains the FIFO, no push, no error
    cyc();
    chk("stall_valid", 32'(out_valid), 32'd0);
    chk("stall_data",  32'(out_data),  32'd0);
    chk("stall_err",   32'(slot_err),  32'd0);

    // Backpressure: 12 slots with out_ready=0 -> 8 held, 4 dropped
    out_ready   = 1'b0;
    bus_eve     = 1'b1;
    bus_pol_eve = 1'b0;
    for (int n = 13; n <= 24; n++) begin
      gray_count = gray(n);
      cyc();
    end
    chk("full_valid", 32'(out_valid),  32'd1);
    chk("full_head",  32'(out_data),   32'(word(1, 1'b0, 1'b1)));
    chk("full_drop",  32'(drop_count), 32'd4);

    // Simultaneous pop and push at full
    out_ready  = 1'b1;
    gray_count = gray(25);
    cyc();
    chk("pp_drop", 32'(drop_count), 32'd4);
    chk("pp_head", 32'(out_data),   32'(word(tz(14) + 1, 1'b0, 1'b1)));

    // Drain: 7 more words (n=15..20, then 25), then empty
    for (int j = 1; j <= 7; j++) begin
      int nexp;
      nexp = (j <= 6) ? 14 + j : 25;
      cyc();
      chk($sformatf("drain_%0d", j), 32'(out_data), 32'(word(tz(nexp) + 1, 1'b0, 1'b1)));
    end
    cyc();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Two-bit jump: no push, sticky error
    gray_count = gray_count ^ 19'h3;
    cyc();
    chk("jump_valid", 32'(out_valid), 32'd0);
    chk("jump_err",   32'(slot_err),  32'd1);
    tog(4, 1'b1, 1'b1);
    chk("after_jump_data", 32'(out_data), 32'(word(5, 1'b1, 1'b1)));
    chk("err_sticky",      32'(slot_err), 32'd1);

    // Enable low for 5 slots, then re-enable
    enable = 1'b0;
    tog(0, 1'b1, 1'b0);
    chk("dis_valid_0", 32'(out_valid), 32'd0);
    tog(1, 1'b1, 1'b0);
    tog(0, 1'b1, 1'b0);
    tog(2, 1'b1, 1'b0);
    tog(0, 1'b1, 1'b0);
    chk("dis_valid_4", 32'(out_valid), 32'd0);
    enable = 1'b1;
    tog(6, 1'b1, 1'b0);
    chk("reen_valid", 32'(out_valid), 32'd1);
    chk("reen_data",  32'(out_data),  32'(word(7, 1'b0, 1'b1)));

    // Queue 5 words, then reset mid-operation
    cyc();
    out_ready = 1'b0;
    tog(0, 1'b1, 1'b0);
    tog(1, 1'b0, 1'b1);
    tog(0, 1'b1, 1'b0);
    tog(2, 1'b1, 1'b0);
    tog(0, 1'b1, 1'b0);
    chk("q5_head", 32'(out_data), 32'(word(1, 1'b0, 1'b1)));
    reset = 1'b1;
    cyc();
    chk("mrst_valid", 32'(out_valid),  32'd0);
    chk("mrst_data",  32'(out_data),   32'd0);
    chk("mrst_drop",  32'(drop_count), 32'd0);
    chk("mrst_err",   32'(slot_err),   32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    tog(1, 1'b1, 1'b0);
    chk("mrst_prime", 32'(out_valid), 32'd0);
    tog(2, 1'b1, 1'b1);
    chk("mrst_valid2", 32'(out_valid), 32'd1);
    chk("mrst_data2",  32'(out_data),  32'(word(3, 1'b1, 1'b1)));
    chk("mrst_err2",   32'(slot_err),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_capture.md
# ro_capture

Capture stage directly downstream of the per-channel readout blocks (`ro_block_1` … `ro_block_19`). It watches the shared tristated readout bus pair (`out_mux_eve`, `out_mux_pol_eve`) together with the gray-coded slot counter. Each bus sample is attributed to the channel whose gray bit toggled, and the stage packs `{channel, pol_eve, eve}` words into a small FIFO. The FIFO is drained by the host-side serializer over a valid/ready handshake.

## Interface
Parameters:
- `N_CH`, 19, number of gray bits / readout channels; gray bit k serves channel k+1
- `CH_W`, 5, channel index width; must satisfy 2^CH_W > N_CH
- `FIFO_DEPTH`, 8, capture FIFO entries; power of two, ≥2
- `DROP_W`, 8, width of the saturating drop counter

Ports:
- `clk_master`  in  1  master clock; gray counter advances on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  capture enable; when low, no words are pushed
- `gray_count`  in  N_CH  gray slot counter, updated just after each `posedge clk_master`
- `bus_eve`  in  1  shared readout bus, event bit; pad keeper holds the last driven value through the low phase
- `bus_pol_eve`  in  1  shared readout bus, polarity bit; same keeper behaviour
- `out_data`  out  CH_W+2  FIFO head `{ch_idx, pol, eve}`; ch_idx is 1-based
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head when high together with `out_valid`
- `drop_count`  out  DROP_W  words lost to FIFO full; saturates at all-ones
- `slot_err`  out  1  sticky; set on a non-one-hot gray transition

## Operation
- Slot decode: at every `posedge clk_master`:
  - register `gray_q <= gray_count`.
  - `delta = gray_count ^ gray_q` (pre-update value).
  - If `delta` is exactly one-hot at bit k, the current `bus_eve`/`bus_pol_eve` belong to channel k+1.
- The bus and the new gray value are sampled on the same edge. The sample is the value driven during the preceding high phase and held by the keeper.
- `primed` flag: cleared by reset, set after the first post-reset edge. Decode is suppressed while `primed`=0.
- `delta`==0 (counter stalled): no push, no error.
- `delta` with ≥2 bits set: no push, `slot_err`<=1 (sticky until reset).
- MSB wrap (`100…0`→`000…0`) is one-hot and is treated as a normal slot for channel N_CH.
- Push condition: `primed & enable & one-hot delta`. The word is `{k+1, bus_pol_eve, bus_eve}`.
- FIFO states (derived from count): EMPTY, PARTIAL, FULL.
  - Push when FULL with no pop: word dropped, `drop_count` +1 (saturating).
  - Push and pop on the same edge when FULL: both accepted, count unchanged.
  - Pop when EMPTY: ignored.
- `gray_q` tracks `gray_count` regardless of `enable`, so that re-enabling never misattributes a slot.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `drop_count`=0, `slot_err`=0, FIFO empty, `primed`=0, `gray_q`=0.
- Reset mid-operation flushes the FIFO and clears all counters and flags on that edge. Decode resumes after one priming edge.
- Latency: gray toggle right after edge t → sampled and pushed at edge t+1 → `out_valid` high after edge t+1, with `out_data` showing the word if the FIFO was empty.
- `out_data` is registered and stable while `out_valid` is high and `out_ready` is low.
- `out_data` is driven to 0 while the FIFO is empty.
- Sustained throughput is one push per cycle. Channel k+1 recurs every 2^(k+1) cycles.

## Configuration
- `RO_CAPTURE_SPARSE_EN` defined: push only when `bus_eve | bus_pol_eve` is 1. All-zero slots are discarded and do not count as drops.
- Not defined: every valid slot is pushed, including zero words, giving a dense, slot-complete stream.

## Structure
- Package `ro_capture_pkg` holds:
  - typedef `ro_word_t` (packed `ch_idx`, `pol`, `eve`)
  - localparams `RO_CH_W`, `RO_N_CH`
  - function `onehot_idx` (returns index plus a valid flag)
- Sub-module `ro_capture_fifo`: synchronous single-clock FIFO with `push`, `pop`, `full`, `empty`, and a registered head. The top level holds the decode, `primed`, drop and error logic.

## Test plan
- Reset, then a binary→gray counter at 1 word/cycle with the bus held at eve=1/pol=0 and `out_ready`=1 → the first word appears two edges after reset release; the ch_idx sequence is 1,2,1,3,1,2,1,4…
- Channel 3 toggles with bus eve=1, pol=1 → `out_data`=`{5'd3,1,1}`. Without the macro, zero slots yield `{ch,0,0}` words. With `RO_CAPTURE_SPARSE_EN`, zero slots yield no words.
- `out_ready`=0 for 12 slots, `FIFO_DEPTH`=8 → 8 words held, `drop_count`=4. A simultaneous pop+push at full keeps the count at 8 and leaves `drop_count` unchanged.
- Force `gray_count` to jump by two bits → no push, `slot_err`=1 and it stays set. Hold `gray_count` constant → no push, no error.
- `enable`=0 for 5 cycles, then 1 → no words during the gap. The first word after re-enable carries the correct channel.
- Assert `reset` with 5 words queued → after that edge `out_valid`=0, `drop_count`=0, `slot_err`=0. The next word appears two edges after release.
